// File: rtl/writeback_release_tracker_pkg.sv
// Shared FU codes, default sizing and entry layout for the writeback release tracker.
package writeback_release_tracker_pkg;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_LOAD = 2'd1,
    FU_AES  = 2'd2,
    FU_RSVD = 2'd3
  } fu_e;

  typedef enum logic [1:0] {
    SB_NOP    = 2'd0,
    SB_ALLOC  = 2'd1,
    SB_RETIRE = 2'd2,
    SB_FLUSH  = 2'd3
  } sb_op_e;

  localparam int WRT_DEPTH    = 4;
  localparam int WRT_ALU_LAT  = 2;
  localparam int WRT_SPEC_WIN = 2;
  localparam int TIMER_W      = 4;
  localparam int AGE_W        = 4;

  typedef struct packed {
    logic               valid;
    logic [4:0]         rd;
    fu_e                fu;
    logic               done;
    logic [TIMER_W-1:0] timer;
    logic [AGE_W-1:0]   age;
  } entry_t;

endpackage

// File: rtl/writeback_release_tracker.sv
// In-order tracker of register-writing instructions: busy bits while in flight,
// one registered writeback pulse per cycle from the head, kill drops the speculative tail.
module writeback_release_tracker
  import writeback_release_tracker_pkg::*;
#(
  parameter int DEPTH    = WRT_DEPTH,
  parameter int ALU_LAT  = WRT_ALU_LAT,
  parameter int SPEC_WIN = WRT_SPEC_WIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [1:0]  issue_fu,
  output logic        issue_ready,
  input  logic        kill,
  input  logic        mem_ack,
  input  logic        aes_done,
  output logic [31:0] busy_vec,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [2:0]  count
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  entry_t          r_ent [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [2:0]      r_count;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;

  logic            w_ld_hit;
  logic [PW-1:0]   w_ld_idx;
  logic            w_aes_hit;
  logic [PW-1:0]   w_aes_idx;
  logic [2:0]      w_nspec;
  logic [31:0]     w_busy;
  logic            w_accept;
  logic            w_head_spec;
  logic            w_retire;
  logic [PW-1:0]   w_head_nxt;
  logic [PW-1:0]   w_tail_inc;
  logic [PW-1:0]   w_tail_kill;
  logic [2:0]      w_count_nxt;

  // Oldest-first search from the head; under kill only non-speculative entries may complete.
  always_comb begin
    logic [PW-1:0] k;
    logic          elig;
    k         = '0;
    elig      = 1'b0;
    w_ld_hit  = 1'b0;
    w_ld_idx  = '0;
    w_aes_hit = 1'b0;
    w_aes_idx = '0;
    w_nspec   = '0;
    w_busy    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      k    = PW'((int'(r_head) + i) % DEPTH);
      elig = r_ent[k].valid && !r_ent[k].done && !(kill && (r_ent[k].age != '0));
      if (!w_ld_hit && elig && (r_ent[k].fu == FU_LOAD)) begin
        w_ld_hit = 1'b1;
        w_ld_idx = k;
      end
      if (!w_aes_hit && elig && (r_ent[k].fu == FU_AES)) begin
        w_aes_hit = 1'b1;
        w_aes_idx = k;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ent[i].valid) begin
        w_busy[r_ent[i].rd] = 1'b1;
        if (r_ent[i].age != '0) w_nspec = w_nspec + 3'd1;
      end
    end
  end

  assign issue_ready = (r_count < DEPTH_C);
  assign w_accept    = issue_valid && issue_ready && !kill &&
                       (issue_rd != 5'd0) && (issue_fu != FU_RSVD);
  assign w_head_spec = (r_ent[r_head].age != '0);
  // A speculative head that is killed must not also write back.
  assign w_retire    = r_ent[r_head].valid && r_ent[r_head].done && !(kill && w_head_spec);
  assign w_head_nxt  = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
  assign w_tail_inc  = (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
  assign w_tail_kill = PW'((int'(r_tail) + DEPTH - int'(w_nspec)) % DEPTH);
  assign w_count_nxt = r_count + {2'b00, w_accept} - {2'b00, w_retire} -
                       (kill ? w_nspec : 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].valid) begin
          if (r_ent[i].age != '0) r_ent[i].age <= r_ent[i].age - 1'b1;
          if ((r_ent[i].fu == FU_ALU) && !r_ent[i].done) begin
            if (r_ent[i].timer <= TIMER_W'(1)) begin
              r_ent[i].timer <= '0;
              r_ent[i].done  <= 1'b1;
            end else begin
              r_ent[i].timer <= r_ent[i].timer - 1'b1;
            end
          end
        end
      end
      if (mem_ack && w_ld_hit)   r_ent[w_ld_idx].done  <= 1'b1;
      if (aes_done && w_aes_hit) r_ent[w_aes_idx].done <= 1'b1;
      if (w_retire) begin
        r_ent[r_head].valid <= 1'b0;
        r_wb_valid          <= 1'b1;
        r_wb_rd             <= r_ent[r_head].rd;
        r_head              <= w_head_nxt;
      end
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_ent[i].valid && (r_ent[i].age != '0)) r_ent[i].valid <= 1'b0;
        end
        r_tail <= w_tail_kill;
      end else if (w_accept) begin
        r_ent[r_tail].valid <= 1'b1;
        r_ent[r_tail].rd    <= issue_rd;
        r_ent[r_tail].fu    <= fu_e'(issue_fu);
        r_ent[r_tail].done  <= (fu_e'(issue_fu) == FU_ALU) && (ALU_LAT == 0);
        r_ent[r_tail].timer <= TIMER_W'(ALU_LAT);
        r_ent[r_tail].age   <= AGE_W'(SPEC_WIN);
        r_tail              <= w_tail_inc;
      end
      r_count <= w_count_nxt;
    end
  end

  assign busy_vec = w_busy;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign count    = r_count;

endmodule
